// File: rtl/md_io_port_if.sv
// ============================================================================
//  Module      : md_io_port_if
//  Description : 68k-side bus bundle for the controller/expansion I/O port
//                block: arbiter I/O select, latched address/strobe/data and
//                the read data return path.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface md_io_port_if;
   logic       IO;      // active-low I/O select from the arbiter (async)
   logic [3:0] VA_i;    // 68k address bits 4:1
   logic       RW_i;    // 1 = read, 0 = write
   logic       LDS_i;   // active-low lower data strobe
   logic [7:0] VD_i;    // write data, 68k bits 7:0
   logic [7:0] VD_o;    // read data
   logic       VD_oe;   // read data output enable

   // Port block side
   modport slave (
      input  IO, VA_i, RW_i, LDS_i, VD_i,
      output VD_o, VD_oe
   );

   // Bus master / arbiter side
   modport master (
      output IO, VA_i, RW_i, LDS_i, VD_i,
      input  VD_o, VD_oe
   );
endinterface

`default_nettype wire

// File: rtl/md_io_port.sv
// ============================================================================
//  Module      : md_io_port
//  Description : Memory-mapped I/O port block at 0xA10000-0xA1001F. Version
//                register, three 7-bit bidirectional ports with per-bit
//                direction, and a TH falling-edge interrupt request (HL).
//                Bus termination stays in the arbiter; this block decodes,
//                latches and drives data only.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module md_io_port #(
   parameter logic       OVERSEAS = 1'b1,   // version bit 7
   parameter logic       PAL      = 1'b0,   // version bit 6
   parameter logic [3:0] VERSION  = 4'h0    // version bits 3:0
) (
   input  logic        MCLK,
   input  logic        SRES,
   md_io_port_if.slave bus,
   input  logic [6:0]  PA_i,
   input  logic [6:0]  PB_i,
   input  logic [6:0]  PC_i,
   output logic [6:0]  PA_o,
   output logic [6:0]  PB_o,
   output logic [6:0]  PC_o,
   output logic [6:0]  PA_oe,
   output logic [6:0]  PB_oe,
   output logic [6:0]  PC_oe,
   input  logic        DISK,
   output logic        HL
);

   // Access sequencer: one EXEC cycle per IO fall, then DRIVE while a read
   // is being returned.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_DRIVE = 2'd2;

   localparam int NPORT = 3;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic                   io_s1_q,   io_s1_d;
   logic                   io_s2_q,   io_s2_d;
   logic                   io_prev_q, io_prev_d;
   logic [1:0]             vld_q,     vld_d;     // sync pipeline holds real samples
   logic                   armed_q,   armed_d;   // IO seen high since reset
   logic [NPORT-1:0][6:0]  pin_s1_q,  pin_s1_d;
   logic [NPORT-1:0][6:0]  pin_s2_q,  pin_s2_d;
   logic [NPORT-1:0]       th_prev_q, th_prev_d;
   logic                   disk_s1_q, disk_s1_d;
   logic                   disk_s2_q, disk_s2_d;

   logic [1:0]             state_q,   state_d;
   logic [3:0]             va_q,      va_d;
   logic                   rw_q,      rw_d;
   logic                   lds_q,     lds_d;
   logic [7:0]             wd_q,      wd_d;

   logic [NPORT-1:0][7:0]  data_q,    data_d;
   logic [NPORT-1:0][7:0]  ctrl_q,    ctrl_d;
   logic [NPORT-1:0]       pend_q,    pend_d;
   logic [7:0]             vd_o_q,    vd_o_d;

   // ---------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------
   logic [NPORT-1:0][6:0]  w_pins;
   logic                   w_start;
   logic                   w_exec;
   logic                   w_wr;
   logic [7:0]             w_rd_data;
   logic [NPORT-1:0]       w_th_fall;
   logic [NPORT-1:0]       w_pend_clr;

   assign w_pins = {PC_i, PB_i, PA_i};

   // A falling edge of the synced select only counts once IO has really
   // been observed high after reset; this stops a select that is still low
   // at reset release from being taken as a fresh access.
   assign w_start = armed_q & io_prev_q & ~io_s2_q;
   assign w_exec  = (state_q == ST_EXEC);
   assign w_wr    = w_exec & ~rw_q & ~lds_q;

   // Read mux for the latched address; port input bits come from the synced pins
   always_comb begin
      w_rd_data = 8'h00;
      if (va_q == 4'h0) begin
         w_rd_data = {OVERSEAS, PAL, ~disk_s2_q, 1'b0, VERSION};
      end
      for (int p = 0; p < NPORT; p++) begin
         if (va_q == 4'(p + 1)) begin
            w_rd_data = {data_q[p][7],
                         (ctrl_q[p][6:0] & data_q[p][6:0]) |
                         (~ctrl_q[p][6:0] & pin_s2_q[p])};
         end
      end
   end

   // TH falling-edge detect and pending-flag clear conditions per port
   always_comb begin
      w_th_fall  = '0;
      w_pend_clr = '0;
      for (int p = 0; p < NPORT; p++) begin
         w_th_fall[p]  = ctrl_q[p][7] & ~ctrl_q[p][6] &
                         th_prev_q[p] & ~pin_s2_q[p][6];
         w_pend_clr[p] = (w_exec & rw_q & (va_q == 4'(p + 1))) |
                         (w_wr & (va_q == 4'(p + 4)) & ~wd_q[7]);
      end
   end

   // Next-state logic: synchronizers, access sequencer, registers, interrupts
   always_comb begin
      io_s1_d   = bus.IO;
      io_s2_d   = io_s1_q;
      io_prev_d = io_s2_q;
      vld_d     = {vld_q[0], 1'b1};
      armed_d   = armed_q | (vld_q[1] & io_s2_q);
      pin_s1_d  = w_pins;
      pin_s2_d  = pin_s1_q;
      disk_s1_d = DISK;
      disk_s2_d = disk_s1_q;
      for (int p = 0; p < NPORT; p++) begin
         th_prev_d[p] = pin_s2_q[p][6];
      end

      state_d = state_q;
      va_d    = va_q;
      rw_d    = rw_q;
      lds_d   = lds_q;
      wd_d    = wd_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      vd_o_d  = vd_o_q;

      case (state_q)
         ST_EXEC: begin
            if (rw_q) begin
               vd_o_d  = w_rd_data;
               state_d = ST_DRIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (io_s2_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Registers at 0x7-0xF and the version register ignore writes
      if (w_wr) begin
         for (int p = 0; p < NPORT; p++) begin
            if (va_q == 4'(p + 1)) begin
               data_d[p] = wd_q;
            end
            if (va_q == 4'(p + 4)) begin
               ctrl_d[p] = wd_q;
            end
         end
      end

      // Edge detection uses ctrl as it was before any same-cycle write;
      // a new edge beats a same-cycle clear.
      for (int p = 0; p < NPORT; p++) begin
         pend_d[p] = w_th_fall[p] | (pend_q[p] & ~w_pend_clr[p]);
      end

      // Bus inputs are captured on the start cycle itself
      if (w_start) begin
         va_d    = bus.VA_i;
         rw_d    = bus.RW_i;
         lds_d   = bus.LDS_i;
         wd_d    = bus.VD_i;
         state_d = ST_EXEC;
      end
   end

   // State registers with synchronous active-low reset; synchronizers reset high
   always_ff @(posedge MCLK) begin
      if (!SRES) begin
         io_s1_q   <= 1'b1;
         io_s2_q   <= 1'b1;
         io_prev_q <= 1'b1;
         vld_q     <= 2'b00;
         armed_q   <= 1'b0;
         pin_s1_q  <= '1;
         pin_s2_q  <= '1;
         th_prev_q <= '1;
         disk_s1_q <= 1'b1;
         disk_s2_q <= 1'b1;
         state_q   <= ST_IDLE;
         va_q      <= 4'h0;
         rw_q      <= 1'b1;
         lds_q     <= 1'b1;
         wd_q      <= 8'h00;
         data_q    <= '0;
         ctrl_q    <= '0;
         pend_q    <= '0;
         vd_o_q    <= 8'h00;
      end else begin
         io_s1_q   <= io_s1_d;
         io_s2_q   <= io_s2_d;
         io_prev_q <= io_prev_d;
         vld_q     <= vld_d;
         armed_q   <= armed_d;
         pin_s1_q  <= pin_s1_d;
         pin_s2_q  <= pin_s2_d;
         th_prev_q <= th_prev_d;
         disk_s1_q <= disk_s1_d;
         disk_s2_q <= disk_s2_d;
         state_q   <= state_d;
         va_q      <= va_d;
         rw_q      <= rw_d;
         lds_q     <= lds_d;
         wd_q      <= wd_d;
         data_q    <= data_d;
         ctrl_q    <= ctrl_d;
         pend_q    <= pend_d;
         vd_o_q    <= vd_o_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.VD_o  = vd_o_q;
   // Drops combinationally on the first cycle the synced select is high
   assign bus.VD_oe = (state_q == ST_DRIVE) & ~io_s2_q;

   assign PA_o  = data_q[0][6:0];
   assign PB_o  = data_q[1][6:0];
   assign PC_o  = data_q[2][6:0];
   assign PA_oe = ctrl_q[0][6:0];
   assign PB_oe = ctrl_q[1][6:0];
   assign PC_oe = ctrl_q[2][6:0];

   assign HL = ~(|pend_q);

endmodule

`default_nettype wire

// File: doc/md_io_port.md
Name: md_io_port

Overview:
- Memory-mapped controller/expansion I/O port block at 68k 0xA10000–0xA1001F.
- Sits directly downstream of the bus arbiter and consumes its IO select strobe.
- Provides the version register, three 7-bit bidirectional ports (A, B, C) with per-bit direction control, and a TH-edge external interrupt request toward the 68k interrupt logic.
- Bus cycle termination (DTACK) stays in the arbiter; this block only decodes, latches and drives data.

Parameters:
- OVERSEAS, 1, version register bit 7 (1 = export console)
- PAL, 0, version register bit 6 (1 = 50 Hz)
- VERSION, 4'h0, version register bits 3:0

Ports:
- MCLK  in  1  system clock; all state changes on rising edge
- SRES  in  1  reset, synchronous, active-low
- IO  in  1  active-low I/O select from the arbiter, asynchronous to MCLK
- VA_i  in  4  68k address bits 4:1, selects register 0x0–0xF
- RW_i  in  1  1 = read, 0 = write
- LDS_i  in  1  active-low lower data strobe
- VD_i  in  8  68k data bits 7:0
- VD_o  out  8  read data
- VD_oe  out  1  read data output enable
- PA_i / PB_i / PC_i  in  7 each  port pin inputs, asynchronous
- PA_o / PB_o / PC_o  out  7 each  port output values
- PA_oe / PB_oe / PC_oe  out  7 each  per-bit output enables (= direction bits)
- DISK  in  1  active-low expansion-present input
- HL  out  1  active-low external interrupt request

Behaviour:
- Synchronizers: IO, all port pins and DISK each pass through 2 flops. Pin changes are visible in read data 2 MCLK after the edge.
- Access detection: start = synced IO goes 1→0. Exactly one access per IO assertion; IO held low for many cycles does not repeat the access.
- Latching: VA_i, RW_i, LDS_i and VD_i are captured on the start cycle.
- Write: on the cycle after start, if RW=0 and LDS=0, update the addressed register. If LDS=1, no write takes place.
- Register map:
  - 0x0: version, read-only. Reads {OVERSEAS, PAL, ~DISK_sync, 1'b0, VERSION}.
  - 0x1–0x3: data A/B/C, 8 bits stored.
  - 0x4–0x6: ctrl A/B/C. Bit 7 = interrupt enable; bits 6:0 = direction (1 = output).
  - 0x7–0xF: read 0x00; writes ignored.
- Data read for a port: bit 7 = stored data bit 7. Bit n (0–6) = ctrl[n] ? data[n] : pin_sync[n].
- Port outputs: Px_o = data[6:0]; Px_oe = ctrl[6:0]. Both are registered and update the cycle after the write.
- Read path: VD_o is registered on the cycle after start and holds its value while synced IO=0 and RW=1.
  - VD_oe=1 over exactly that interval.
  - VD_oe=0 on the first cycle synced IO=1.
  - VD_o holds its last value when not enabled.
- Interrupt:
  - Per port, when ctrl[7]=1, ctrl[6]=0 (TH is an input) and synced TH goes 1→0, set the pending flag.
  - HL = ~(pendA | pendB | pendC).
  - A read of that port's data register clears its pending flag on the cycle after start.
  - If a new edge arrives on the same cycle as the clear, set wins.
  - Writing ctrl[7]=0 clears pending.
- Reset (SRES=0 at a rising edge):
  - All data registers = 0x00 and all ctrl registers = 0x00, so every port is input and Px_oe=0, Px_o=0.
  - Pending flags = 0, HL=1, VD_oe=0, VD_o=0x00.
  - Synchronizer flops are set to 1, so no spurious edge is seen after reset.
  - An access in progress is abandoned: no write, no read drive.
  - An IO still low when reset releases is not treated as a new access until IO returns high and falls again.
- Simultaneous events: a write to ctrl that changes a direction takes effect for reads starting the next cycle. A pin edge and a ctrl write on the same cycle use the ctrl value from before the write.

Test Plan:
- Reset, OVERSEAS=1, PAL=0, DISK=1: read 0x0 → VD_o=0x80 with VD_oe=1. Px_oe=0, HL=1.
- Write ctrl A=0x40, then data A=0x40 (LDS=0) → PA_oe=0x40 and PA_o=0x40 one cycle after the write. Read data A with PA_i=0x3F → 0x7F.
- Write with LDS=1 → registers unchanged. IO held low for 20 cycles with RW=0 → only one write.
- PB_i bit 0 toggles → read data B reflects it only from 2 MCLK after the toggle.
- ctrl A=0x80, PA_i[6] goes 1→0 → HL=0 within 3 MCLK. Read data A → HL=1. A TH fall on the clear cycle → HL stays 0.
- SRES pulsed low during a write access with IO held low → no register update, VD_oe=0. The next IO fall performs the access normally.
